// File: rtl/seq_calculator.sv
// Clocked calculator: one-cycle concat/add/sub/signed-add/counter readout and a
// WIDTH-cycle shift-add unsigned multiply behind a start/busy/done handshake.
module seq_calculator #(
  parameter int WIDTH = 4
) (
  input  logic                 clk_pi,
  input  logic                 rst_n_pi,
  input  logic                 start_pi,
  input  logic [WIDTH-1:0]     data1_pi,
  input  logic [WIDTH-1:0]     data2_pi,
  input  logic [3:0]           op_pi,
  input  logic                 clear_pi,
  output logic [2*WIDTH-1:0]   result_po,
  output logic                 ovflw_po,
  output logic                 busy_po,
  output logic                 done_po,
  output logic                 sticky_ovflw_po
);

  localparam int RW = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [RW-1:0] CNT_ONE  = RW'(1);
  localparam logic [WIDTH-1:0] ZERO_W = '0;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [RW-1:0]     acc_q, acc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     result_q, result_d;
  logic              ovflw_q, ovflw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sticky_q, sticky_d;

  logic [WIDTH:0]    add_s;
  logic [WIDTH-1:0]  sub_s;
  logic [WIDTH-1:0]  sadd_s;
  logic              sadd_ov_s;

  assign add_s     = {1'b0, data1_pi} + {1'b0, data2_pi};
  assign sub_s     = data1_pi - data2_pi;
  assign sadd_s    = data1_pi + data2_pi;
  assign sadd_ov_s = (data1_pi[WIDTH-1] == data2_pi[WIDTH-1]) &&
                     (sadd_s[WIDTH-1] != data1_pi[WIDTH-1]);

  // Next-state: request decode in IDLE, one shift-add step per cycle in MUL.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    ovflw_d  = ovflw_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q + CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (start_pi) begin
          a_d = data1_pi;
          b_d = data2_pi;
          case (op_pi)
            4'b0000: begin
              result_d = {data1_pi, data2_pi};
              ovflw_d  = 1'b0;
              done_d   = 1'b1;
            end
            4'b0001: begin
              result_d = {ZERO_W, add_s[WIDTH-1:0]};
              ovflw_d  = add_s[WIDTH];
              done_d   = 1'b1;
            end
            4'b0010: begin
              result_d = {ZERO_W, sub_s};
              ovflw_d  = (data1_pi < data2_pi);
              done_d   = 1'b1;
            end
            4'b0100: begin
              acc_d   = '0;
              idx_d   = '0;
              state_d = ST_MUL;
            end
            4'b1000: begin
              result_d = {ZERO_W, sadd_s};
              ovflw_d  = sadd_ov_s;
              done_d   = 1'b1;
            end
            default: begin
              // Readout sees the counter value before this edge's increment.
              result_d = cnt_q;
              ovflw_d  = 1'b0;
              done_d   = 1'b1;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (b_q[idx_q]) begin
          acc_d = acc_q + ({ZERO_W, a_q} << idx_q);
        end else begin
          acc_d = acc_q;
        end
        idx_d = idx_q + IDX_ONE;
        if (idx_q == LAST_IDX) begin
          result_d = acc_d;
          ovflw_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_MUL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky overflow: a new overflow completion outranks a same-cycle clear.
  always_comb begin
    busy_d = (state_d == ST_MUL);
    if (done_d && ovflw_d) begin
      sticky_d = 1'b1;
    end else if (clear_pi) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovflw_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovflw_q  <= ovflw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sticky_q <= sticky_d;
    end
  end

  assign result_po       = result_q;
  assign ovflw_po        = ovflw_q;
  assign busy_po         = busy_q;
  assign done_po         = done_q;
  assign sticky_ovflw_po = sticky_q;

endmodule
